tt_mux_sel_seq: RTL and testbench

TT_MUX_SEL_SEQ -- requirements
Module: tt_mux_sel_seq

---
 rtl/tt_mux_sel_seq.sv | 163 ++++++++++++++++
 tb/tb_tt_mux_sel_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_sel_seq.sv
// tt_mux_sel_seq
// Selects one project on the shared mux. The mux select counter is reset,
// then advanced by one increment pulse per address step, then the mux is
// enabled. Each control phase lasts PULSE_W cycles.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   selection handshake (ready is the only comb output)
//   req_addr          target project address
//   abort             cancels a sequence in progress (no effect when idle)
//   disable_i         drops ctrl_ena while idle
//   ctrl_sel_rst_n    mux select-counter reset   (pad ctrl[2])
//   ctrl_sel_inc      mux select-counter inc     (pad ctrl[1])
//   ctrl_ena          mux enable                 (pad ctrl[0])
//   busy              high while not IDLE
//   done              1-cycle pulse on completion
//   err               1-cycle pulse on out-of-range request
//   sel_addr          last successfully selected address
module tt_mux_sel_seq #(
    parameter int ADDR_W   = 10,
    parameter int NUM_PROJ = 512,
    parameter int PULSE_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              abort,
    input  logic              disable_i,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] sel_addr
);
    localparam int PHW = $clog2(PULSE_W + 1);
    localparam int PCW = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1;
    localparam logic [PHW-1:0]  PH_LOAD = PHW'(PULSE_W - 1);
    // One extra bit so NUM_PROJ == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NP      = (ADDR_W + 1)'(NUM_PROJ);

    typedef enum logic [2:0] {IDLE, RST, SETTLE, INC_HI, INC_LO, ENA} state_t;

    state_t            state;
    logic [PHW-1:0]    phase;   // cycles left in current phase, minus one
    logic [PCW-1:0]    pcnt;    // increment pulses still to emit
    logic [ADDR_W-1:0] addr_q;

    assign req_ready = (state == IDLE) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            phase          <= '0;
            pcnt           <= '0;
            addr_q         <= '0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            sel_addr       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && state != IDLE) begin
                state          <= IDLE;
                busy           <= 1'b0;
                ctrl_sel_rst_n <= 1'b1;
                ctrl_sel_inc   <= 1'b0;
                ctrl_ena       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // Releases the counter reset on the first clock after rst_n.
                        ctrl_sel_rst_n <= 1'b1;
                        if (req_valid && !abort) begin
                            if ({1'b0, req_addr} < NP) begin
                                addr_q         <= req_addr;
                                pcnt           <= PCW'(req_addr);
                                phase          <= PH_LOAD;
                                ctrl_ena       <= 1'b0;
                                ctrl_sel_rst_n <= 1'b0;
                                busy           <= 1'b1;
                                state          <= RST;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (disable_i) begin
                            ctrl_ena <= 1'b0;
                        end
                    end
                    RST: begin
                        if (phase == '0) begin
                            phase          <= PH_LOAD;
                            ctrl_sel_rst_n <= 1'b1;
                            state          <= SETTLE;
                        end else begin
                            phase <= phase - 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (phase == '0) begin
                            phase <= PH_LOAD;
                            if (addr_q == '0) begin
                                ctrl_ena <= 1'b1;
                                done     <= 1'b1;
                                sel_addr <= addr_q;
                                state    <= ENA;
                            end else begin
                                ctrl_sel_inc <= 1'b1;
                                state        <= INC_HI;
                            end
                        end else begin
                            phase <= phase - 1'b1;
                        end
                    end
                    INC_HI: begin
                        if (phase == '0) begin
                            phase        <= PH_LOAD;
                            ctrl_sel_inc <= 1'b0;
                            state        <= INC_LO;
                        end else begin
                            phase <= phase - 1'b1;
                        end
                    end
                    INC_LO: begin
                        if (phase == '0) begin
                            phase <= PH_LOAD;
                            // pcnt==1 means this pair was the last one.
                            if (pcnt == PCW'(1)) begin
                                pcnt     <= '0;
                                ctrl_ena <= 1'b1;
                                done     <= 1'b1;
                                sel_addr <= addr_q;
                                state    <= ENA;
                            end else begin
                                pcnt         <= pcnt - 1'b1;
                                ctrl_sel_inc <= 1'b1;
                                state        <= INC_HI;
                            end
                        end else begin
                            phase <= phase - 1'b1;
                        end
                    end
                    ENA: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_mux_sel_seq.sv
// Directed bench for tt_mux_sel_seq at PULSE_W=2, NUM_PROJ=512.
module tb_tt_mux_sel_seq;
    localparam int AW = 10;
    localparam int PW = 2;
    localparam int NP = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          abort;
    logic          disable_i;
    logic          ctrl_sel_rst_n;
    logic          ctrl_sel_inc;
    logic          ctrl_ena;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] sel_addr;

    int n_tests = 0;
    int n_fail  = 0;

    tt_mux_sel_seq #(.ADDR_W(AW), .NUM_PROJ(NP), .PULSE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .abort(abort), .disable_i(disable_i),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
        .ctrl_ena(ctrl_ena), .busy(busy), .done(done), .err(err),
        .sel_addr(sel_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; sample point is 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Run one full selection of address a. If hold_valid, req_valid stays
    // high during the sequence and must never be seen as ready.
    task automatic run_sel(input string tag, input logic [AW-1:0] a, input bit hold_valid);
        int n, rises, hi, rlow, dcyc, dcnt, bad_rdy;
        logic prev, ena_n;
        n = 2 * PW * (int'(a) + 1) + 1;
        rises = 0; hi = 0; rlow = 0; dcyc = 0; dcnt = 0; bad_rdy = 0;
        prev = 1'b0; ena_n = 1'b0;
        chk({tag, "_rdy0"}, req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        step(1);
        if (!hold_valid) req_valid = 1'b0;
        chk({tag, "_rst_c1"}, ctrl_sel_rst_n, 0);
        chk({tag, "_ena_c1"}, ctrl_ena, 0);
        for (int c = 1; c <= n + 1; c++) begin
            if (ctrl_sel_inc && !prev) rises++;
            if (ctrl_sel_inc) hi++;
            if (!ctrl_sel_rst_n) rlow++;
            if (done) begin
                dcnt++;
                if (dcyc == 0) dcyc = c;
            end
            if (busy && req_ready) bad_rdy++;
            prev = ctrl_sel_inc;
            if (c == n) begin
                ena_n = ctrl_ena;
                req_valid = 1'b0;
            end
            if (c <= n) step(1);
        end
        chk({tag, "_inc_pulses"}, rises, a);
        chk({tag, "_inc_hi_cyc"}, hi, 2 * a);
        chk({tag, "_rst_lo_cyc"}, rlow, PW);
        chk({tag, "_done_cyc"}, dcyc, n);
        chk({tag, "_done_cnt"}, dcnt, 1);
        chk({tag, "_ena_at_done"}, ena_n, 1);
        chk({tag, "_sel_addr"}, sel_addr, a);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_ena_after"}, ctrl_ena, 1);
        if (hold_valid) chk({tag, "_rdy_busy"}, bad_rdy, 0);
    endtask

    initial begin
        int rises, bsy;
        logic prev;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; abort = 1'b0; disable_i = 1'b0;
        #12;
        // Reset state
        chk("rst_sel_rst_n", ctrl_sel_rst_n, 0);
        chk("rst_inc", ctrl_sel_inc, 0);
        chk("rst_ena", ctrl_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_sel_addr", sel_addr, 0);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_sel_rst_n", ctrl_sel_rst_n, 1);

        // Address 0: no increments, done at cycle 5
        run_sel("a0", 10'd0, 1'b0);
        // Address 3: three increment pulses, done at cycle 17
        run_sel("a3", 10'd3, 1'b0);

        // Out of range: err in cycle 1, nothing else moves
        req_valid = 1'b1; req_addr = 10'd512;
        step(1);
        req_valid = 1'b0;
        chk("oor_err_c1", err, 1);
        chk("oor_busy", busy, 0);
        chk("oor_ena", ctrl_ena, 1);
        chk("oor_sel_addr", sel_addr, 3);
        chk("oor_sel_rst_n", ctrl_sel_rst_n, 1);
        bsy = 0;
        for (int c = 2; c <= 6; c++) begin
            step(1);
            if (busy) bsy++;
        end
        chk("oor_busy_never", bsy, 0);
        chk("oor_err_pulse", err, 0);

        // Disable while idle drops ctrl_ena
        disable_i = 1'b1;
        step(1);
        disable_i = 1'b0;
        chk("dis_ena", ctrl_ena, 0);

        // Address 5, abort during the second INC_LO (cycles 11-12)
        req_valid = 1'b1; req_addr = 10'd5;
        step(1);
        req_valid = 1'b0;
        rises = 0; prev = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (ctrl_sel_inc && !prev) rises++;
            prev = ctrl_sel_inc;
            if (c < 11) step(1);
        end
        chk("abt_in_inc_lo", ctrl_sel_inc, 0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abt_busy", busy, 0);
        chk("abt_ena", ctrl_ena, 0);
        chk("abt_inc", ctrl_sel_inc, 0);
        chk("abt_sel_rst_n", ctrl_sel_rst_n, 1);
        chk("abt_done", done, 0);
        chk("abt_sel_addr", sel_addr, 3);
        chk("abt_pulses", rises, 2);
        step(2);
        chk("abt_no_done_later", done, 0);

        // req_valid held while busy is ignored
        run_sel("hold", 10'd1, 1'b1);

        // abort + req_valid in the same IDLE cycle: no accept, no effect
        abort = 1'b1; req_valid = 1'b1; req_addr = 10'd4;
        #1;
        chk("abtv_rdy", req_ready, 0);
        step(1);
        abort = 1'b0; req_valid = 1'b0;
        chk("abtv_busy", busy, 0);
        chk("abtv_ena", ctrl_ena, 1);
        chk("abtv_sel_addr", sel_addr, 1);

        // Reset pulsed during INC_HI (cycles 5-6 for addr 3)
        req_valid = 1'b1; req_addr = 10'd3;
        step(1);
        req_valid = 1'b0;
        step(4);
        chk("rmid_inc_hi", ctrl_sel_inc, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_inc", ctrl_sel_inc, 0);
        chk("rmid_ena", ctrl_ena, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_sel_addr", sel_addr, 0);
        #3;
        rst_n = 1'b1;
        step(1);
        chk("rmid_rel_sel_rst_n", ctrl_sel_rst_n, 1);
        chk("rmid_rel_busy", busy, 0);
        bsy = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (done || busy) bsy++;
        end
        chk("rmid_no_done", bsy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
